key_press_ctrl: RTL and testbench
=================================

Name: key_press_ctrl

Overview:
- Parametrised multi-channel push-button processor for the 50 MHz board clock.
- Each active-low key channel is synchronised and debounced, then classified as a short press or a long hold.
- Produces one-cycle event pulses, a held level, and a per-channel LED state that toggles on every long-press event.
- Successor to the single-key long-press/LED-toggle logic: adds N channels, debounce, short/long discrimination, reset and auto-repeat.

Parameters:
N_KEYS, 4, number of independent key channels (1..16).
DEB_CYC, 1000000, stable-level cycles required to accept a press or release edge (20 ms at 50 MHz); must be >= 1.
LONG_CYC, 100000000, debounced-hold cycles before a long-press event (2 s); must be >= 1.
REPEAT_CYC, 12500000, auto-repeat period in cycles (used only with the optional feature); must be >= 1.
LED_INIT, {N_KEYS{1'b1}}, LED reset value.

Ports:
FPGA_CLK  input  1  system clock, 50 MHz, all logic on its rising edge.
RST  input  1  asynchronous active-high reset.
KEY  input  N_KEYS  raw keys, active-low (0 = pressed), asynchronous to FPGA_CLK.
SHORT_P  output  N_KEYS  one-cycle pulse per channel on release of a short press.
LONG_P  output  N_KEYS  one-cycle pulse per channel when the hold reaches LONG_CYC (and on each repeat, if enabled).
HELD  output  N_KEYS  high while the channel is in HELD, LONG or DEB_REL.
LED  output  N_KEYS  per-channel LED state; toggles on each long-press event.

Behaviour:
- Reset values (async, held while RST=1):
  - Synchroniser flops = 1 (released).
  - FSM = IDLE; deb_cnt = 0; hold_cnt = 0; was_long = 0.
  - SHORT_P = 0, LONG_P = 0, HELD = 0, LED = LED_INIT.
- Sync: two-flop synchroniser per channel gives key_s. A KEY value sampled at edge k is seen by the FSM at edge k+2.
- Counters: all outputs registered. deb_cnt width = clog2(DEB_CYC+1). hold_cnt width = clog2(max(LONG_CYC, REPEAT_CYC)+1). Both counters saturate and never wrap.
- Per-channel FSM:
  - IDLE: key_s=0 -> DEB_PRESS, deb_cnt=0.
  - DEB_PRESS: key_s=1 -> IDLE (bounce, no event). Otherwise deb_cnt++. When deb_cnt==DEB_CYC-1 -> HELD, hold_cnt=0, was_long=0.
  - HELD: hold_cnt++ each cycle.
    - hold_cnt==LONG_CYC-1 -> LONG, was_long=1, LONG_P=1 for one cycle, LED toggles in the same cycle.
    - key_s=1 -> DEB_REL, deb_cnt=0.
    - If both conditions occur in the same cycle, release wins: go to DEB_REL, no LONG_P.
  - LONG: key_s=1 -> DEB_REL, deb_cnt=0. hold_cnt is used only by the repeat feature.
  - DEB_REL: hold_cnt is frozen.
    - key_s=0 -> return to LONG if was_long, else HELD (bounce on release; hold timing resumes).
    - deb_cnt++. When deb_cnt==DEB_CYC-1 -> IDLE. If was_long=0, SHORT_P=1 for one cycle.
- Latency: press sampled low at edge k, held continuously:
  - HELD asserts after edge k+2+DEB_CYC.
  - LONG_P is high for exactly the cycle after edge k+2+DEB_CYC+LONG_CYC.
- Per press: at most one SHORT_P or one LONG_P, never both (repeats excepted).
- Channels are fully independent. Simultaneous events on several channels pulse the corresponding bits in the same cycle.
- Reset mid-operation: returns to reset state immediately. No pulse is emitted on RST deassertion, even if a key is held; that key must pass DEB_PRESS again.

Optional Feature:
KEY_AUTOREPEAT_EN
- Defined:
  - In LONG with key_s=0, hold_cnt restarts at 0 on entry. Each time it reaches REPEAT_CYC-1 it reloads to 0 and LONG_P pulses again for one cycle.
  - LED toggles only on the first long event.
  - Repeat timing freezes in DEB_REL and resumes on bounce-back.
- Undefined:
  - Exactly one LONG_P per press. No repeat counter logic is synthesised.

Test Plan:
1. Bench params N_KEYS=2, DEB_CYC=4, LONG_CYC=16, REPEAT_CYC=8. Assert RST with KEY=2'b00, release at edge 5, hold KEY low -> all outputs 0 and LED=2'b11 during reset. HELD[0] rises after edge 5+2+4, LONG_P[0] high one cycle after edge 27, LED[0]=0.
2. KEY[0] low at edge 10 for 10 cycles, then high -> HELD[0] after edge 16. SHORT_P[0] one cycle after edge 20+2+4. LONG_P=0 and LED unchanged.
3. KEY[1] glitches low for 3 cycles, twice -> channel stays IDLE; no HELD, SHORT_P or LONG_P.
4. Long press on channel 0, then a 2-cycle high glitch at release, then a clean release -> glitch returns FSM to LONG. Clean release gives IDLE with no SHORT_P and exactly one LONG_P.
5. Both keys pressed at the same edge for 30 cycles -> LONG_P=2'b11 in the same cycle; both LED bits toggle.
6. RST pulse mid-hold on channel 0 (hold_cnt=10) -> LED back to 1s and HELD=0. With KEY still low, a new LONG_P appears 22 cycles after RST deassertion. With KEY_AUTOREPEAT_EN, LONG_P repeats every 8 cycles while held.

Source files
------------

// File: rtl/key_press_ctrl.sv
// Multi-channel push-button processor: sync, debounce, short/long press classification, LED toggle.
// Optional auto-repeat of LONG_P while held is enabled by defining KEY_AUTOREPEAT_EN.
`timescale 1ns/1ps
module key_press_ctrl #(
  parameter int                N_KEYS     = 4,
  parameter int                DEB_CYC    = 1000000,
  parameter int                LONG_CYC   = 100000000,
  parameter int                REPEAT_CYC = 12500000,
  parameter logic [N_KEYS-1:0] LED_INIT   = {N_KEYS{1'b1}}
) (
  input  logic              FPGA_CLK,
  input  logic              RST,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] SHORT_P,
  output logic [N_KEYS-1:0] LONG_P,
  output logic [N_KEYS-1:0] HELD,
  output logic [N_KEYS-1:0] LED
);

  localparam int HOLD_MAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int DW       = $clog2(DEB_CYC + 1);
  localparam int HW       = $clog2(HOLD_MAX + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
  localparam logic [DW-1:0] DEB_ONE   = DW'(1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
`ifdef KEY_AUTOREPEAT_EN
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYC - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DEB_PRESS = 3'd1,
    ST_HELD      = 3'd2,
    ST_LONG      = 3'd3,
    ST_DEB_REL   = 3'd4
  } state_e;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    logic          sync1_q, sync2_q;
    logic          key_s;
    state_e        state_q;
    logic [DW-1:0] deb_cnt_q;
    logic [HW-1:0] hold_cnt_q;
    logic          was_long_q;
    logic          short_q, long_q, held_q, led_q;

    assign key_s      = sync2_q;
    assign SHORT_P[g] = short_q;
    assign LONG_P[g]  = long_q;
    assign HELD[g]    = held_q;
    assign LED[g]     = led_q;

    // Two-flop synchroniser; resets to the released level.
    always_ff @(posedge FPGA_CLK or posedge RST) begin
      if (RST) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
      end else begin
        sync1_q <= KEY[g];
        sync2_q <= sync1_q;
      end
    end

    // Per-channel press FSM with registered event pulses, held level and LED.
    always_ff @(posedge FPGA_CLK or posedge RST) begin
      if (RST) begin
        state_q    <= ST_IDLE;
        deb_cnt_q  <= '0;
        hold_cnt_q <= '0;
        was_long_q <= 1'b0;
        short_q    <= 1'b0;
        long_q     <= 1'b0;
        held_q     <= 1'b0;
        led_q      <= LED_INIT[g];
      end else begin
        short_q <= 1'b0;
        long_q  <= 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (!key_s) begin
              state_q   <= ST_DEB_PRESS;
              deb_cnt_q <= '0;
            end
          end
          ST_DEB_PRESS: begin
            if (key_s) begin
              state_q <= ST_IDLE;
            end else if (deb_cnt_q == DEB_LAST) begin
              state_q    <= ST_HELD;
              held_q     <= 1'b1;
              hold_cnt_q <= '0;
              was_long_q <= 1'b0;
            end else begin
              deb_cnt_q <= deb_cnt_q + DEB_ONE;
            end
          end
          ST_HELD: begin
            // Release takes priority over a coincident long threshold.
            if (key_s) begin
              state_q   <= ST_DEB_REL;
              deb_cnt_q <= '0;
            end else if (hold_cnt_q == LONG_LAST) begin
              state_q    <= ST_LONG;
              was_long_q <= 1'b1;
              long_q     <= 1'b1;
              led_q      <= ~led_q;
              hold_cnt_q <= '0;
            end else begin
              hold_cnt_q <= hold_cnt_q + HOLD_ONE;
            end
          end
          ST_LONG: begin
            if (key_s) begin
              state_q   <= ST_DEB_REL;
              deb_cnt_q <= '0;
            end else begin
`ifdef KEY_AUTOREPEAT_EN
              if (hold_cnt_q == REP_LAST) begin
                hold_cnt_q <= '0;
                long_q     <= 1'b1;
              end else begin
                hold_cnt_q <= hold_cnt_q + HOLD_ONE;
              end
`else
              hold_cnt_q <= hold_cnt_q;
`endif
            end
          end
          ST_DEB_REL: begin
            // hold_cnt stays frozen here so a release bounce resumes timing.
            if (!key_s) begin
              state_q <= was_long_q ? ST_LONG : ST_HELD;
            end else if (deb_cnt_q == DEB_LAST) begin
              state_q <= ST_IDLE;
              held_q  <= 1'b0;
              short_q <= ~was_long_q;
            end else begin
              deb_cnt_q <= deb_cnt_q + DEB_ONE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            held_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_press_ctrl.sv
// Scoreboard bench for key_press_ctrl: directed key timelines push expected pulses, a monitor pops and compares.
`timescale 1ns/1ps
module tb_key_press_ctrl;

  localparam int NK  = 2;
  localparam int DEB = 4;
  localparam int LNG = 16;
  localparam int REP = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key = 2'b00;
  logic [NK-1:0] short_p, long_p, held, led;

  key_press_ctrl #(
    .N_KEYS(NK), .DEB_CYC(DEB), .LONG_CYC(LNG), .REPEAT_CYC(REP), .LED_INIT(2'b11)
  ) dut (
    .FPGA_CLK(clk), .RST(rst), .KEY(key),
    .SHORT_P(short_p), .LONG_P(long_p), .HELD(held), .LED(led)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] sp;
    logic [1:0] lp;
    logic [1:0] ld;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_ev;
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int c, input logic [1:0] sp, input logic [1:0] lp, input logic [1:0] ld);
    exp_q.push_back('{c, sp, lp, ld});
  endtask

  // Returns at #1 after edge e.
  task automatic goto(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every pulse must match the oldest expected event; overdue events are reported.
  always @(negedge clk) begin
    if (!rst) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("missing_event", 32'(cyc), 32'(exp_q[0].cyc));
        void'(exp_q.pop_front());
      end
      if ((short_p | long_p) != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {28'd0, short_p, long_p}, 32'd0);
        end else begin
          mon_ev = exp_q.pop_front();
          check("event_cycle", 32'(cyc), 32'(mon_ev.cyc));
          check("short_p", {30'd0, short_p}, {30'd0, mon_ev.sp});
          check("long_p", {30'd0, long_p}, {30'd0, mon_ev.lp});
          check("led", {30'd0, led}, {30'd0, mon_ev.ld});
        end
      end
    end
  end

  initial begin
    // 1: reset state, then long press on ch0 (sampled from edge 5)
    goto(3);
    check("rst_held", {30'd0, held}, 32'd0);
    check("rst_short", {30'd0, short_p}, 32'd0);
    check("rst_long", {30'd0, long_p}, 32'd0);
    check("rst_led", {30'd0, led}, 32'd3);
    expect_ev(27, 2'b00, 2'b01, 2'b10);
    goto(4);  rst = 1'b0; key = 2'b10;
    goto(10); check("t1_held_pre", {30'd0, held}, 32'd0);
    goto(11); check("t1_held_rise", {30'd0, held}, 32'd1);
    goto(29); key = 2'b11;
    goto(35); check("t1_held_rel", {30'd0, held}, 32'd1);
    goto(36); check("t1_held_fall", {30'd0, held}, 32'd0);

    // 2: short press on ch0, low edges 40..49
    expect_ev(56, 2'b01, 2'b00, 2'b10);
    goto(39); key = 2'b10;
    goto(45); check("t2_held_pre", {30'd0, held}, 32'd0);
    goto(46); check("t2_held_rise", {30'd0, held}, 32'd1);
    goto(49); key = 2'b11;
    goto(56); check("t2_held_fall", {30'd0, held}, 32'd0);

    // 3: two 3-cycle glitches on ch1 never leave debounce
    for (int e = 59; e <= 75; e++) begin
      goto(e);
      key = (e inside {59, 60, 61, 65, 66, 67}) ? 2'b01 : 2'b11;
      if (e >= 60) check("t3_glitch_held", {30'd0, held}, 32'd0);
    end

    // 4: long press ch0 with a 2-cycle release glitch, then clean release
    expect_ev(102, 2'b00, 2'b01, 2'b11);
    goto(79);  key = 2'b10;
    goto(104); key = 2'b11;
    goto(106); key = 2'b10;
    goto(108); check("t4_held_glitch", {30'd0, held}, 32'd1);
    goto(109); key = 2'b11;
    goto(115); check("t4_held_rel", {30'd0, held}, 32'd1);
    goto(116); check("t4_held_fall", {30'd0, held}, 32'd0);

    // 5: both keys together for 30 cycles
    expect_ev(152, 2'b00, 2'b11, 2'b00);
`ifdef KEY_AUTOREPEAT_EN
    expect_ev(160, 2'b00, 2'b11, 2'b00);
`endif
    goto(129); key = 2'b00;
    goto(159); key = 2'b11;
    goto(165); check("t5_held_both", {30'd0, held}, 32'd3);
    goto(166); check("t5_held_fall", {30'd0, held}, 32'd0);

    // 6: reset mid-hold (hold_cnt=10), key kept low
    goto(179); key = 2'b10;
    goto(186); check("t6_held_rise", {30'd0, held}, 32'd1);
    goto(196); rst = 1'b1;
    goto(198);
    check("t6_rst_held", {30'd0, held}, 32'd0);
    check("t6_rst_led", {30'd0, led}, 32'd3);
    check("t6_rst_long", {30'd0, long_p}, 32'd0);
    expect_ev(221, 2'b00, 2'b01, 2'b10);
`ifdef KEY_AUTOREPEAT_EN
    expect_ev(229, 2'b00, 2'b01, 2'b10);
    expect_ev(237, 2'b00, 2'b01, 2'b10);
`endif
    rst = 1'b0;
    goto(204); check("t6_held_pre", {30'd0, held}, 32'd0);
    goto(205); check("t6_held_rise2", {30'd0, held}, 32'd1);
    goto(239); key = 2'b11;
    goto(246); check("t6_held_fall", {30'd0, held}, 32'd0);

    goto(260);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_led", {30'd0, led}, 32'd2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
